// File: rtl/clock_hands_render.sv
// Analog clock hand renderer: a fixed 3-cycle pixel pipeline that overlays
// second, minute and hour hands on a background colour stream.
module clock_hands_render #(
    parameter int          CX         = 320,
    parameter int          CY         = 240,
    parameter int          SEC_LEN    = 155,
    parameter int          MIN_LEN    = 130,
    parameter int          HOUR_LEN   = 100,
    parameter int          SEC_HW     = 1,
    parameter int          MIN_HW     = 4,
    parameter int          HOUR_HW    = 7,
    parameter logic [23:0] SEC_COLOR  = 24'hff0000,
    parameter logic [23:0] MIN_COLOR  = 24'h00ff00,
    parameter logic [23:0] HOUR_COLOR = 24'h0000ff,
    parameter int          FRAC       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [5:0]  hour,
    input  logic [5:0]  min,
    input  logic [5:0]  sec,
    input  logic [2:0]  hand_en,
    input  logic        pix_valid,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic [23:0] bg_color,
    output logic [23:0] data,
    output logic        data_valid
);

    localparam int LEN [3] = '{SEC_LEN, MIN_LEN, HOUR_LEN};
    localparam int HW  [3] = '{SEC_HW, MIN_HW, HOUR_HW};

    function automatic logic signed [11:0] f_tab(input logic [3:0] i);
        logic signed [11:0] v;
        v = 12'sd0;
        unique case (i)
            4'd0:  v = 12'sd0;
            4'd1:  v = 12'sd107;
            4'd2:  v = 12'sd213;
            4'd3:  v = 12'sd316;
            4'd4:  v = 12'sd416;
            4'd5:  v = 12'sd512;
            4'd6:  v = 12'sd602;
            4'd7:  v = 12'sd685;
            4'd8:  v = 12'sd761;
            4'd9:  v = 12'sd828;
            4'd10: v = 12'sd887;
            4'd11: v = 12'sd935;
            4'd12: v = 12'sd974;
            4'd13: v = 12'sd1002;
            4'd14: v = 12'sd1018;
            4'd15: v = 12'sd1024;
        endcase
        return v;
    endfunction

    // Returns {sin, cos}; quadrant folds the index onto the 0..90 degree table.
    function automatic logic [23:0] f_sincos(input logic [5:0] k);
        logic [1:0]         q;
        logic [3:0]         r;
        logic signed [11:0] a, b, s, c;
        if (k >= 6'd45) begin
            q = 2'd3;
            r = 4'(k - 6'd45);
        end else if (k >= 6'd30) begin
            q = 2'd2;
            r = 4'(k - 6'd30);
        end else if (k >= 6'd15) begin
            q = 2'd1;
            r = 4'(k - 6'd15);
        end else begin
            q = 2'd0;
            r = k[3:0];
        end
        a = f_tab(r);
        b = f_tab(4'd15 - r);
        s = a;
        c = b;
        unique case (q)
            2'd0: begin s = a;  c = b;  end
            2'd1: begin s = b;  c = -a; end
            2'd2: begin s = -a; c = -b; end
            2'd3: begin s = -b; c = a;  end
        endcase
        return {s, c};
    endfunction

    logic [5:0] w_sec_new, w_min_new, w_hour_new, w_min_div, w_h12;
    logic [5:0] w_sec_idx, w_min_idx, w_hour_idx;
    logic [5:0] r_sec_idx, r_min_idx, r_hour_idx;

    assign w_sec_new  = (sec > 6'd59) ? 6'd0 : sec;
    assign w_min_new  = (min > 6'd59) ? 6'd0 : min;
    assign w_min_div  = w_min_new / 6'd12;
    assign w_h12      = (hour >= 6'd12) ? hour - 6'd12 : hour;
    assign w_hour_new = (hour > 6'd23) ? 6'd0 : w_h12 * 6'd5 + w_min_div;

    // A pixel arriving with frame_start already sees the new angles.
    assign w_sec_idx  = frame_start ? w_sec_new  : r_sec_idx;
    assign w_min_idx  = frame_start ? w_min_new  : r_min_idx;
    assign w_hour_idx = frame_start ? w_hour_new : r_hour_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec_idx  <= '0;
            r_min_idx  <= '0;
            r_hour_idx <= '0;
        end else if (frame_start) begin
            r_sec_idx  <= w_sec_new;
            r_min_idx  <= w_min_new;
            r_hour_idx <= w_hour_new;
        end
    end

    logic [23:0]        w_sc [3];
    logic signed [10:0] w_dx, w_dy;

    always_comb begin
        w_sc[0] = f_sincos(w_sec_idx);
        w_sc[1] = f_sincos(w_min_idx);
        w_sc[2] = f_sincos(w_hour_idx);
    end

    assign w_dx = signed'({1'b0, h_addr}) - 11'(CX);
    assign w_dy = 11'(CY) - signed'({1'b0, v_addr});

    logic               r1_valid;
    logic [23:0]        r1_bg;
    logic [2:0]         r1_en;
    logic signed [10:0] r1_dx, r1_dy;
    logic signed [11:0] r1_sin [3];
    logic signed [11:0] r1_cos [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_bg    <= '0;
            r1_en    <= '0;
            r1_dx    <= '0;
            r1_dy    <= '0;
            for (int i = 0; i < 3; i++) begin
                r1_sin[i] <= '0;
                r1_cos[i] <= '0;
            end
        end else begin
            r1_valid <= pix_valid;
            r1_bg    <= bg_color;
            r1_en    <= hand_en;
            r1_dx    <= w_dx;
            r1_dy    <= w_dy;
            for (int i = 0; i < 3; i++) begin
                r1_sin[i] <= signed'(w_sc[i][23:12]);
                r1_cos[i] <= signed'(w_sc[i][11:0]);
            end
        end
    end

    // Rotate the pixel offset into each hand's frame.
    logic signed [23:0] w_al [3];
    logic signed [23:0] w_pp [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_al[i] = (24'(r1_dx) * 24'(r1_sin[i])
                     + 24'(r1_dy) * 24'(r1_cos[i])) >>> FRAC;
            w_pp[i] = (24'(r1_dx) * 24'(r1_cos[i])
                     - 24'(r1_dy) * 24'(r1_sin[i])) >>> FRAC;
        end
    end

    logic               r2_valid;
    logic [23:0]        r2_bg;
    logic [2:0]         r2_en;
    logic signed [23:0] r2_al [3];
    logic signed [23:0] r2_pp [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_valid <= 1'b0;
            r2_bg    <= '0;
            r2_en    <= '0;
            for (int i = 0; i < 3; i++) begin
                r2_al[i] <= '0;
                r2_pp[i] <= '0;
            end
        end else begin
            r2_valid <= r1_valid;
            r2_bg    <= r1_bg;
            r2_en    <= r1_en;
            for (int i = 0; i < 3; i++) begin
                r2_al[i] <= w_al[i];
                r2_pp[i] <= w_pp[i];
            end
        end
    end

    logic [2:0]  w_hit;
    logic [23:0] w_color;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 3; i++) begin
            w_hit[i] = r2_en[i]
                && (r2_al[i] >= 24'sd0)
                && (r2_al[i] <= 24'(LEN[i]))
                && (r2_pp[i] >= -24'(HW[i]))
                && (r2_pp[i] <= 24'(HW[i]));
        end
    end

    always_comb begin
        w_color = r2_bg;
        priority case (1'b1)
            w_hit[0]: w_color = SEC_COLOR;
            w_hit[1]: w_color = MIN_COLOR;
            w_hit[2]: w_color = HOUR_COLOR;
            default:  w_color = r2_bg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data       <= r2_valid ? w_color : 24'h0;
            data_valid <= r2_valid;
        end
    end

endmodule

// File: tb/tb_clock_hands_render.sv
// Directed bench for clock_hands_render: hand geometry, priority,
// boundaries, per-frame latching and reset behaviour.
module tb_clock_hands_render;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [5:0]  t_hour, t_min, t_sec;
    logic [2:0]  hand_en;
    logic        pix_valid;
    logic [9:0]  h_addr, v_addr;
    logic [23:0] bg_color;
    logic [23:0] data;
    logic        data_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    clock_hands_render dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .hour       (t_hour),
        .min        (t_min),
        .sec        (t_sec),
        .hand_en    (hand_en),
        .pix_valid  (pix_valid),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .bg_color   (bg_color),
        .data       (data),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %06h, want %06h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic [23:0] bg);
        pix_valid = 1'b1;
        h_addr    = 10'(h);
        v_addr    = 10'(v);
        bg_color  = bg;
    endtask

    task automatic px(input string tag, input int h, input int v,
                      input logic [23:0] bg, input logic [23:0] exp);
        drive(h, v, bg);
        step();
        pix_valid = 1'b0;
        step();
        step();
        chk(tag, data, exp);
    endtask

    task automatic frm(input int h, input int m, input int s);
        t_hour      = 6'(h);
        t_min       = 6'(m);
        t_sec       = 6'(s);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        t_hour      = '0;
        t_min       = '0;
        t_sec       = '0;
        hand_en     = 3'b111;
        pix_valid   = 1'b0;
        h_addr      = '0;
        v_addr      = '0;
        bg_color    = '0;
        step();
        step();
        chk("rst_data", data, 24'h0);
        chk("rst_valid", 24'(data_valid), 24'd0);
        reset = 1'b0;

        // Reset angles point at 12 o'clock.
        px("t1_sec12", 320, 100, 24'h0, 24'hFF0000);
        chk("t1_valid", 24'(data_valid), 24'd1);

        // sec=15 (3 o'clock), min=30 (6 o'clock), hour idx 2.
        frm(0, 30, 15);
        px("t2_sec", 400, 240, 24'h123456, 24'hFF0000);
        px("t2_min", 320, 350, 24'h123456, 24'h00FF00);
        px("t2_hour", 332, 181, 24'h123456, 24'h0000FF);
        px("t2_bg", 10, 10, 24'h123456, 24'h123456);

        frm(0, 0, 0);
        px("prio_sec", 320, 200, 24'h123456, 24'hFF0000);
        hand_en = 3'b110;
        px("prio_min", 320, 200, 24'h123456, 24'h00FF00);

        hand_en = 3'b001;
        px("len_in", 320, 85, 24'h123456, 24'hFF0000);
        px("len_out", 320, 84, 24'h123456, 24'h123456);
        px("hw_in", 321, 200, 24'h123456, 24'hFF0000);
        px("hw_out", 322, 200, 24'h123456, 24'h123456);
        px("hwn_in", 319, 200, 24'h123456, 24'hFF0000);
        px("hwn_out", 318, 200, 24'h123456, 24'h123456);
        px("along0", 320, 240, 24'h123456, 24'hFF0000);
        px("alongn", 320, 241, 24'h123456, 24'h123456);

        // Pixel coinciding with frame_start uses the new angle.
        t_sec       = 6'd15;
        frame_start = 1'b1;
        drive(400, 240, 24'h123456);
        step();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        step();
        step();
        chk("same_cycle", data, 24'hFF0000);

        // hour 13, min 36 -> hour idx 8 (48 degrees).
        frm(13, 36, 0);
        hand_en = 3'b100;
        px("hour_idx8", 391, 176, 24'h123456, 24'h0000FF);
        t_sec   = 6'd15;
        hand_en = 3'b001;
        px("no_tear", 320, 100, 24'h123456, 24'hFF0000);
        frm(13, 36, 15);
        px("next_frame", 320, 100, 24'h123456, 24'h123456);

        // Continuous stream with an asynchronous reset at pixel 100.
        frm(0, 0, 0);
        hand_en = 3'b111;
        for (int i = 0; i <= 100; i++) begin
            drive(i, 10, 24'hA00000 + 24'(i));
            if (i == 100) begin
                #2 reset = 1'b1;
                #1;
                chk("async_data", data, 24'h0);
                chk("async_valid", 24'(data_valid), 24'd0);
            end else begin
                step();
                if (i == 50) begin
                    chk("stream_bg", data, 24'hA00000 + 24'd48);
                    chk("stream_valid", 24'(data_valid), 24'd1);
                end
            end
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 101; i < 640; i++) begin
            drive(i, 10, 24'hA00000 + 24'(i));
            step();
            if (i == 101) chk("rel_lat1", 24'(data_valid), 24'd0);
            if (i == 102) chk("rel_lat2", 24'(data_valid), 24'd0);
            if (i == 103) begin
                chk("rel_lat3", 24'(data_valid), 24'd1);
                chk("rel_data", data, 24'hA00000 + 24'd101);
            end
        end
        pix_valid = 1'b0;
        step();
        step();
        step();
        chk("stream_idle", 24'(data_valid), 24'd0);

        // Out-of-range time inputs latch as zero.
        frm(0, 30, 15);
        frm(0, 60, 60);
        hand_en = 3'b001;
        px("sec60", 320, 100, 24'h123456, 24'hFF0000);
        hand_en = 3'b010;
        px("min60", 320, 200, 24'h123456, 24'h00FF00);
        hand_en = 3'b100;
        px("min60_hour", 320, 200, 24'h123456, 24'h0000FF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
